// File: rtl/sign_narrower.sv
`default_nettype none
// ============================================================================
// Module   : sign_narrower
// Purpose  : Scans a 16-bit two's-complement word from bit 14 downward. It
//            finds the minimum signed width of the word, then produces an
//            OUT_WIDTH-bit narrowed copy of it. The copy saturates to the
//            most positive or most negative OUT_WIDTH-bit value when the
//            word does not fit in that width.
// Revision : 1.0 - initial release
// ============================================================================
module sign_narrower #(
    parameter int OUT_WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [15:0]          value,
    output logic                 busy,
    output logic                 done,
    output logic [4:0]           min_width,
    output logic                 fits,
    output logic [OUT_WIDTH-1:0] narrow
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_SCAN = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [4:0]           c_OUT_W   = 5'(OUT_WIDTH);
    localparam logic [OUT_WIDTH-1:0] c_MAX_POS = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0] c_MIN_NEG = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    logic [1:0]           r_state;
    logic [15:0]          r_op;
    logic [3:0]           r_idx;

    logic                 w_differ;
    logic                 w_finish;
    logic [4:0]           w_mw;
    logic                 w_fits;
    logic [OUT_WIDTH-1:0] w_narrow;

    // Scan-step decode: the first bit below the sign that disagrees with it
    // sets the width. Reaching bit 0 with no disagreement means width 1.
    always_comb begin
        w_differ = (r_op[r_idx] != r_op[15]);
        w_finish = w_differ || (r_idx == 4'd0);
        w_mw     = w_differ ? ({1'b0, r_idx} + 5'd2) : 5'd1;
        w_fits   = (w_mw <= c_OUT_W);
        if (w_fits) begin
            w_narrow = r_op[OUT_WIDTH-1:0];
        end else if (r_op[15]) begin
            w_narrow = c_MIN_NEG;
        end else begin
            w_narrow = c_MAX_POS;
        end
    end

    // Control FSM and registered outputs. The result registers change only on
    // the edge that enters DONE, so they hold steady through a following scan.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_op      <= 16'd0;
            r_idx     <= 4'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            min_width <= 5'd0;
            fits      <= 1'b0;
            narrow    <= '0;
        end else begin
            case (r_state)
                c_IDLE, c_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_op    <= value;
                        r_idx   <= 4'd14;
                        busy    <= 1'b1;
                        r_state <= c_SCAN;
                    end else begin
                        busy    <= 1'b0;
                        r_state <= c_IDLE;
                    end
                end
                c_SCAN: begin
                    if (w_finish) begin
                        r_state   <= c_DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        min_width <= w_mw;
                        fits      <= w_fits;
                        narrow    <= w_narrow;
                    end else begin
                        r_idx <= r_idx - 4'd1;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sign_narrower.sv
`default_nettype none
// ============================================================================
// Module   : tb_sign_narrower
// Purpose  : Self-checking bench for sign_narrower. It uses one instance with
//            OUT_WIDTH=5 and one with OUT_WIDTH=9, and checks both against an
//            arithmetic range-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sign_narrower;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start5 = 1'b0, start9 = 1'b0;
    logic [15:0] value5 = 16'd0, value9 = 16'd0;
    logic        busy5, done5, fits5, busy9, done9, fits9;
    logic [4:0]  mw5, mw9;
    logic [4:0]  narrow5;
    logic [8:0]  narrow9;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sign_narrower #(.OUT_WIDTH(5)) dut5 (
        .clk(clk), .rst(rst), .start(start5), .value(value5),
        .busy(busy5), .done(done5), .min_width(mw5), .fits(fits5), .narrow(narrow5)
    );

    sign_narrower #(.OUT_WIDTH(9)) dut9 (
        .clk(clk), .rst(rst), .start(start9), .value(value9),
        .busy(busy9), .done(done9), .min_width(mw9), .fits(fits9), .narrow(narrow9)
    );

    // Reference: the smallest w whose signed range [-2^(w-1), 2^(w-1)-1] holds v.
    function automatic int ref_mw(input logic [15:0] v);
        int s;
        s = int'($signed(v));
        for (int w = 1; w <= 16; w++) begin
            if (s >= -(1 << (w - 1)) && s <= (1 << (w - 1)) - 1) return w;
        end
        return 16;
    endfunction

    function automatic logic [15:0] ref_narrow(input logic [15:0] v, input int ow);
        int s;
        s = int'($signed(v));
        if (ref_mw(v) <= ow) return 16'(s & ((1 << ow) - 1));
        if (s < 0) return 16'(1 << (ow - 1));
        return 16'((1 << (ow - 1)) - 1);
    endfunction

    task automatic sample(input bit sel, output logic b, output logic d,
                          output logic [4:0] mw, output logic f, output logic [15:0] nr);
        if (sel) begin
            b = busy9; d = done9; mw = mw9; f = fits9; nr = 16'(narrow9);
        end else begin
            b = busy5; d = done5; mw = mw5; f = fits5; nr = 16'(narrow5);
        end
    endtask

    task automatic set_start(input bit sel, input logic s, input logic [15:0] v);
        if (sel) begin start9 = s; value9 = v; end
        else     begin start5 = s; value5 = v; end
    endtask

    // One operation: start is driven at the current negedge. Returns at the
    // negedge of the DONE cycle, so a caller may start again immediately.
    task automatic run_op(input bit sel, input logic [15:0] v, input bit poke);
        int          ow, mw_e, k_e, n;
        bit          f_e, seen, do_poke;
        logic [15:0] nr_e, p_nr, nr;
        logic [4:0]  p_mw, mw;
        logic        p_f, f, b, d, pb, pd;
        ow      = sel ? 9 : 5;
        mw_e    = ref_mw(v);
        k_e     = (mw_e >= 2) ? 17 - mw_e : 15;
        f_e     = (mw_e <= ow);
        nr_e    = ref_narrow(v, ow);
        do_poke = poke && (k_e >= 4);
        sample(sel, pb, pd, p_mw, p_f, p_nr);
        set_start(sel, 1'b1, v);
        @(posedge clk);
        n = 0; seen = 0;
        while (n <= 40) begin
            @(negedge clk);
            if (n == 0) set_start(sel, 1'b0, 16'($urandom));
            if (do_poke && n == 2) set_start(sel, 1'b1, 16'($urandom));
            if (do_poke && n == 3) set_start(sel, 1'b0, 16'($urandom));
            sample(sel, b, d, mw, f, nr);
            if (d === 1'b1) begin
                seen = 1;
                break;
            end
            n_vec++;
            if (b !== 1'b1 || mw !== p_mw || f !== p_f || nr !== p_nr) begin
                n_fail++;
                $display("FAIL scan_hold v=%h cyc=%0d: busy=%b mw=%0d fits=%b nar=%h, want busy=1 mw=%0d fits=%b nar=%h",
                         v, n, b, mw, f, nr, p_mw, p_f, p_nr);
            end
            @(posedge clk);
            n++;
        end
        n_vec++;
        if (!seen) begin
            n_fail++;
            $display("FAIL timeout v=%h: no done within 40 cycles, want done after %0d", v, k_e);
            return;
        end
        if (n !== k_e) begin
            n_fail++;
            $display("FAIL latency v=%h: got %0d want %0d", v, n, k_e);
        end
        n_vec++;
        if (b !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_in_done v=%h: got %b want 0", v, b);
        end
        n_vec++;
        if (mw !== 5'(mw_e)) begin
            n_fail++;
            $display("FAIL min_width v=%h ow=%0d: got %0d want %0d", v, ow, mw, mw_e);
        end
        n_vec++;
        if (f !== f_e) begin
            n_fail++;
            $display("FAIL fits v=%h ow=%0d: got %b want %b", v, ow, f, f_e);
        end
        n_vec++;
        if (nr !== nr_e) begin
            n_fail++;
            $display("FAIL narrow v=%h ow=%0d: got %h want %h", v, ow, nr, nr_e);
        end
    endtask

    // After DONE with no new start, done must drop and the unit must be idle.
    task automatic idle_check(input bit sel);
        logic b, d, f;
        logic [4:0]  mw;
        logic [15:0] nr;
        @(posedge clk);
        @(negedge clk);
        sample(sel, b, d, mw, f, nr);
        n_vec++;
        if (d !== 1'b0 || b !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_done: done=%b busy=%b want 0 0", d, b);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({busy5, done5, mw5, fits5, narrow5} !== 13'd0 ||
            {busy9, done9, mw9, fits9, narrow9} !== 17'd0) begin
            n_fail++;
            $display("FAIL reset_values: dut5=%h dut9=%h want 0 0",
                     {busy5, done5, mw5, fits5, narrow5}, {busy9, done9, mw9, fits9, narrow9});
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [15:0] vals[7];
        vals = '{16'h0005, 16'hFFF0, 16'hFFEF, 16'h7FFF, 16'h8000, 16'h0000, 16'hFFFF};
        foreach (vals[i]) begin
            run_op(1'b0, vals[i], 1'b0);
            idle_check(1'b0);
        end
        run_op(1'b1, 16'h00FF, 1'b0);
        idle_check(1'b1);
        run_op(1'b1, 16'h0100, 1'b0);
        idle_check(1'b1);
    endtask

    task automatic test_back_to_back();
        run_op(1'b0, 16'h0007, 1'b0);
        run_op(1'b0, 16'hFF80, 1'b0);
        run_op(1'b0, 16'h4000, 1'b0);
        run_op(1'b0, 16'hFFFE, 1'b0);
        idle_check(1'b0);
    endtask

    task automatic test_scan_ignore();
        run_op(1'b0, 16'h0003, 1'b1);
        idle_check(1'b0);
        run_op(1'b1, 16'hFFFF, 1'b1);
        idle_check(1'b1);
    endtask

    task automatic test_mid_reset();
        run_op(1'b0, 16'h1234, 1'b0);
        idle_check(1'b0);
        start5 = 1'b1; value5 = 16'h0000;
        @(posedge clk);
        @(negedge clk);
        start5 = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({busy5, done5, mw5, fits5, narrow5} !== 13'd0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: got %h want 0", {busy5, done5, mw5, fits5, narrow5});
        end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_vec++;
            if (done5 !== 1'b0 || busy5 !== 1'b0) begin
                n_fail++;
                $display("FAIL aborted_done cyc=%0d: done=%b busy=%b want 0 0", i, done5, busy5);
            end
        end
        run_op(1'b0, 16'h0000, 1'b0);
        idle_check(1'b0);
    endtask

    task automatic test_random();
        logic signed [15:0] t;
        logic [15:0]        v;
        bit                 sel;
        for (int i = 0; i < 60; i++) begin
            t   = 16'($urandom);
            v   = 16'(t >>> $urandom_range(0, 15));
            sel = 1'($urandom_range(0, 1));
            run_op(sel, v, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 0) idle_check(sel);
        end
        idle_check(1'b0);
        idle_check(1'b1);
    endtask

    initial begin
        test_reset();
        @(negedge clk);
        test_directed();
        test_back_to_back();
        test_scan_ignore();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
